lsu: RTL

Load/store unit sitting between the pipeline's memory stage and `dm`, acting as the initiator on the `dm` port (`MemWrite`/`addr`/`writeData`/`readData`/`PC`). It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. It converts sub-word stores into a word read-modify-write, because `dm` only writes whole words. It also extracts and extends sub-word load data and returns a one-cycle response.

---
 rtl/lsu.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between the memory stage and a word-only dm port
// Sub-word stores become a read-modify-write; sub-word loads are lane-extracted and extended.
module lsu (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic        reqWrite_i,
    input  logic [1:0]  reqSize_i,
    input  logic        reqSigned_i,
    input  logic [31:0] reqAddr_i,
    input  logic [31:0] reqWData_i,
    input  logic [31:0] reqPC_i,
    output logic        dmMemWrite_o,
    output logic [31:0] dmAddr_o,
    output logic [31:0] dmWriteData_o,
    output logic [31:0] dmPC_o,
    input  logic [31:0] dmReadData_i,
    output logic        respValid_o,
    output logic [31:0] respRData_o,
    output logic        respErr_o
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, pc_q, merge_q, rdata_q;
    logic [1:0]  size_q;
    logic        signed_q, err_q, ready_q, valid_q;

    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_d, merge_d;

    assign req_err = (reqSize_i == 2'd3) ||
                     (reqSize_i == 2'd1 && reqAddr_i[0]) ||
                     (reqSize_i == 2'd2 && reqAddr_i[1:0] != 2'b00);

    always_comb begin
        lane_b = dmReadData_i[7:0];
        case (addr_q[1:0])
            2'd1:    lane_b = dmReadData_i[15:8];
            2'd2:    lane_b = dmReadData_i[23:16];
            2'd3:    lane_b = dmReadData_i[31:24];
            default: lane_b = dmReadData_i[7:0];
        endcase
        lane_h = addr_q[1] ? dmReadData_i[31:16] : dmReadData_i[15:0];
        case (size_q)
            2'd0:    load_d = {{24{signed_q & lane_b[7]}}, lane_b};
            2'd1:    load_d = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_d = dmReadData_i;
        endcase
    end

    // Only byte and half stores reach RMW_RD, so size_q is 0 or 1 here.
    always_comb begin
        merge_d = dmReadData_i;
        if (size_q == 2'd0) begin
            case (addr_q[1:0])
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q[15:0];
        end else begin
            merge_d[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (reqValid_i) begin
                    addr_q   <= reqAddr_i;
                    wdata_q  <= reqWData_i;
                    pc_q     <= reqPC_i;
                    size_q   <= reqSize_i;
                    signed_q <= reqSigned_i;
                    ready_q  <= 1'b0;
                    if (req_err) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else if (!reqWrite_i) begin
                        state_q <= LOAD;
                    end else if (reqSize_i == 2'd2) begin
                        merge_q <= reqWData_i;
                        state_q <= STORE;
                    end else begin
                        state_q <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata_q <= load_d;
                    err_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RMW_RD: begin
                    merge_q <= merge_d;
                    state_q <= STORE;
                end
                STORE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write enable straight from the state so an async reset kills it at once.
    assign dmMemWrite_o  = (state_q == STORE);
    assign dmAddr_o      = {addr_q[31:2], 2'b00};
    assign dmWriteData_o = merge_q;
    assign dmPC_o        = pc_q;
    assign reqReady_o    = ready_q;
    assign respValid_o   = valid_q;
    assign respRData_o   = rdata_q;
    assign respErr_o     = err_q;
endmodule
